// File: rtl/riscv_stim_source.sv
// riscv_stim_source
// Stimulus source for RISC-V pipeline bring-up. It produces the instruction
// stream behind a valid/ready handshake. It also answers data-memory reads,
// with a latency that is pipelined and set by a parameter.
// There are two independent generators, one for instructions and one for data.
// Each has a counter and a 32-bit Galois LFSR, and is selected per stream by
// mode: COUNT, LFSR or HOLD.
module riscv_stim_source #(
   parameter int          XLEN       = 32,
   parameter int          ILEN       = 32,
   parameter int          RD_LATENCY = 1,
   parameter int          STEP       = 1,
   parameter logic [31:0] LFSR_SEED  = 32'hACE1_0001
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [1:0]      i_mode,
   input  logic [1:0]      d_mode,
   input  logic            load,
   input  logic [XLEN-1:0] load_val,
   output logic [ILEN-1:0] instruction,
   output logic            instr_valid,
   input  logic            instr_ready,
   input  logic            MemRead,
   input  logic [XLEN-1:0] dAddress,
   output logic [XLEN-1:0] dReadData,
   output logic            dread_valid
);

   localparam logic [1:0]  MODE_COUNT = 2'd0;
   localparam logic [1:0]  MODE_LFSR  = 2'd1;
   localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

   // Widest of XLEN, ILEN and 32. Loads and LFSR values are zero-extended to
   // this width first, so every truncation is a plain slice.
   localparam int WXI  = (XLEN > ILEN) ? XLEN : ILEN;
   localparam int MAXW = (WXI > 32) ? WXI : 32;

   // One Galois step: shift right, XOR the taps when the bit shifted out was 1.
   // A zero result is replaced by the seed so the LFSR can never lock up.
   function automatic logic [31:0] lfsrStep(input logic [31:0] s);
      logic [31:0] n;
      n = s >> 1;
      if (s[0]) n = n ^ LFSR_TAPS;
      if (n == 32'd0) n = LFSR_SEED;
      return n;
   endfunction

   logic [MAXW-1:0] loadWide;
   logic [31:0]     loadLfsr;

   assign loadWide = MAXW'(load_val);
   assign loadLfsr = (loadWide[31:0] == 32'd0) ? LFSR_SEED : loadWide[31:0];

   // ---------------------------------------------------------------------
   // Instruction generator and handshake
   //
   // Handshake: a word moves on a rising edge only when instr_valid and
   // instr_ready are both 1. While instr_valid is 1 and instr_ready is 0, the
   // instruction word stays stable. instr_valid never drops by itself unless
   // en is 0 or load is 1, and a word is never withdrawn and then replaced by
   // a different one. A transfer that finishes on the same edge as en falls is
   // still counted: the generator steps past the accepted word. This way the
   // word is not offered again when en returns.
   // ---------------------------------------------------------------------
   logic [ILEN-1:0] iCount;
   logic [31:0]     iLfsr;
   logic [31:0]     iLfsrNext;
   logic [MAXW-1:0] iLfsrWide;
   logic [MAXW-1:0] iLfsrNextWide;
   logic [ILEN-1:0] iGenOut;
   logic [ILEN-1:0] iGenNext;
   logic            iTransfer;

   assign iLfsrNext     = lfsrStep(iLfsr);
   assign iLfsrWide     = MAXW'(iLfsr);
   assign iLfsrNextWide = MAXW'(iLfsrNext);
   assign iTransfer     = instr_valid & instr_ready;

   // Value the generator shows now (iGenOut) and after one advance (iGenNext).
   always_comb begin
      iGenOut  = instruction;
      iGenNext = instruction;
      if (i_mode == MODE_COUNT) begin
         iGenOut  = iCount;
         iGenNext = iCount + ILEN'(STEP);
      end else if (i_mode == MODE_LFSR) begin
         iGenOut  = iLfsrWide[ILEN-1:0];
         iGenNext = iLfsrNextWide[ILEN-1:0];
      end
   end

   // Instruction state: load first, then transfer, then enable and present.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instruction <= '0;
         instr_valid <= 1'b0;
         iCount      <= '0;
         iLfsr       <= LFSR_SEED;
      end else if (load) begin
         iCount      <= loadWide[ILEN-1:0];
         iLfsr       <= loadLfsr;
         instr_valid <= 1'b0;
      end else if (iTransfer) begin
         if (i_mode == MODE_COUNT) iCount <= iCount + ILEN'(STEP);
         else if (i_mode == MODE_LFSR) iLfsr <= iLfsrNext;
         instruction <= iGenNext;
         instr_valid <= en;
      end else if (!en) begin
         instr_valid <= 1'b0;
      end else if (!instr_valid) begin
         instruction <= iGenOut;
         instr_valid <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Data generator
   // ---------------------------------------------------------------------
   logic [XLEN-1:0] dCount;
   logic [31:0]     dLfsr;
   logic [XLEN-1:0] dHeld;
   logic [MAXW-1:0] dLfsrWide;
   logic [XLEN-1:0] dGenOut;
   logic [XLEN-1:0] reqData;
   logic            dAdv;

   assign dLfsrWide = MAXW'(dLfsr);
   assign dAdv      = MemRead & en & ~load;
   assign reqData   = dGenOut + dAddress;

   // Current data value for the selected mode. HOLD repeats the previous output.
   always_comb begin
      dGenOut = dHeld;
      if (d_mode == MODE_COUNT) dGenOut = dCount;
      else if (d_mode == MODE_LFSR) dGenOut = dLfsrWide[XLEN-1:0];
   end

   // Data state: load has priority. Each enabled read request advances the
   // generator once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dCount <= '0;
         dLfsr  <= LFSR_SEED;
         dHeld  <= '0;
      end else begin
         dHeld <= dGenOut;
         if (load) begin
            dCount <= loadWide[XLEN-1:0];
            dLfsr  <= loadLfsr;
         end else if (dAdv) begin
            if (d_mode == MODE_COUNT) dCount <= dCount + XLEN'(STEP);
            else if (d_mode == MODE_LFSR) dLfsr <= lfsrStep(dLfsr);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Read response path
   // ---------------------------------------------------------------------
   generate
      if (RD_LATENCY == 0) begin : gen_comb
         logic [XLEN-1:0] lastData;

         assign dread_valid = MemRead;
         assign dReadData   = MemRead ? reqData : lastData;

         // Remember the last response so dReadData holds it between reads.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) lastData <= '0;
            else if (MemRead) lastData <= reqData;
         end
      end else begin : gen_pipe
         logic            pipeValid [RD_LATENCY];
         logic [XLEN-1:0] pipeData  [RD_LATENCY];

         assign dread_valid = pipeValid[RD_LATENCY-1];
         assign dReadData   = pipeData[RD_LATENCY-1];

         // Shift pipe. Data moves only along with a valid bit, so the last
         // stage holds the last response. Reset flushes every read in flight.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int k = 0; k < RD_LATENCY; k++) begin
                  pipeValid[k] <= 1'b0;
                  pipeData[k]  <= '0;
               end
            end else begin
               pipeValid[0] <= MemRead;
               if (MemRead) pipeData[0] <= reqData;
               for (int k = 1; k < RD_LATENCY; k++) begin
                  pipeValid[k] <= pipeValid[k-1];
                  if (pipeValid[k-1]) pipeData[k] <= pipeData[k-1];
               end
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_riscv_stim_source.sv
// tb_riscv_stim_source
// Directed bench for riscv_stim_source. A table of per-cycle vectors drives
// the instruction stream. Hand-written sequences cover read latency, a load
// that coincides with a read, and an asynchronous reset in mid-read. Two
// instances share all inputs: one with RD_LATENCY=3, one with RD_LATENCY=0.
module tb_riscv_stim_source;

   logic        clk;
   logic        rst;
   logic        en;
   logic [1:0]  i_mode;
   logic [1:0]  d_mode;
   logic        load;
   logic [31:0] load_val;
   logic        instr_ready;
   logic        mem_read;
   logic [31:0] d_address;

   logic [31:0] instruction3, instruction0;
   logic        instr_valid3, instr_valid0;
   logic [31:0] d_read_data3, d_read_data0;
   logic        dread_valid3, dread_valid0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_q[$];

   riscv_stim_source #(.XLEN(32), .ILEN(32), .RD_LATENCY(3), .STEP(1),
                       .LFSR_SEED(32'hACE1_0001)) dut3 (
      .clk(clk), .rst(rst), .en(en), .i_mode(i_mode), .d_mode(d_mode),
      .load(load), .load_val(load_val), .instruction(instruction3),
      .instr_valid(instr_valid3), .instr_ready(instr_ready),
      .MemRead(mem_read), .dAddress(d_address), .dReadData(d_read_data3),
      .dread_valid(dread_valid3));

   riscv_stim_source #(.XLEN(32), .ILEN(32), .RD_LATENCY(0), .STEP(1),
                       .LFSR_SEED(32'hACE1_0001)) dut0 (
      .clk(clk), .rst(rst), .en(en), .i_mode(i_mode), .d_mode(d_mode),
      .load(load), .load_val(load_val), .instruction(instruction0),
      .instr_valid(instr_valid0), .instr_ready(instr_ready),
      .MemRead(mem_read), .dAddress(d_address), .dReadData(d_read_data0),
      .dread_valid(dread_valid0));

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: act=%h exp=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        en;
      logic [1:0]  mode;
      logic        ready;
      logic        load;
      logic [31:0] load_val;
      logic        exp_valid;
      logic [31:0] exp_instr;
   } vec_t;

   vec_t vecs[26];

   initial begin
      logic [31:0] model_cnt;
      logic [31:0] last_resp;
      logic [31:0] exp_word;
      logic        exp_v;

      // Instruction vectors. Inputs are applied before an edge; expected values are seen after it.
      vecs[0]  = '{1'b1, 2'd0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0000};
      vecs[1]  = '{1'b1, 2'd0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0001};
      vecs[2]  = '{1'b1, 2'd0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0002};
      vecs[3]  = '{1'b1, 2'd0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0003};
      vecs[4]  = '{1'b1, 2'd0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0004};
      vecs[5]  = '{1'b1, 2'd0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0005};
      vecs[6]  = '{1'b1, 2'd0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0005};
      vecs[7]  = '{1'b1, 2'd0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0005};
      vecs[8]  = '{1'b1, 2'd0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0005};
      vecs[9]  = '{1'b1, 2'd0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0006};
      vecs[10] = '{1'b1, 2'd0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0007};
      vecs[11] = '{1'b0, 2'd0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0007};
      vecs[12] = '{1'b0, 2'd0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0007};
      vecs[13] = '{1'b1, 2'd0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0007};
      vecs[14] = '{1'b1, 2'd0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0008};
      vecs[15] = '{1'b1, 2'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0000_0008};
      vecs[16] = '{1'b1, 2'd0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFF};
      vecs[17] = '{1'b1, 2'd0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0000};
      vecs[18] = '{1'b1, 2'd0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0001};
      vecs[19] = '{1'b1, 2'd1, 1'b1, 1'b1, 32'h0,         1'b0, 32'h0000_0001};
      vecs[20] = '{1'b1, 2'd1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hACE1_0001};
      vecs[21] = '{1'b1, 2'd1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hD650_8003};
      vecs[22] = '{1'b1, 2'd1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hEB08_4002};
      vecs[23] = '{1'b1, 2'd1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h7584_2001};
      vecs[24] = '{1'b1, 2'd2, 1'b1, 1'b0, 32'h0,         1'b1, 32'h7584_2001};
      vecs[25] = '{1'b1, 2'd2, 1'b1, 1'b0, 32'h0,         1'b1, 32'h7584_2001};

      // Reset
      rst = 1'b0; en = 1'b0; i_mode = 2'd0; d_mode = 2'd0; load = 1'b0;
      load_val = '0; instr_ready = 1'b0; mem_read = 1'b0; d_address = '0;
      step();
      step();
      check("rst_instr", instruction3, 32'h0);
      check("rst_ivalid", {31'b0, instr_valid3}, 32'h0);
      check("rst_rdata3", d_read_data3, 32'h0);
      check("rst_rvalid3", {31'b0, dread_valid3}, 32'h0);
      check("rst_rdata0", d_read_data0, 32'h0);
      check("rst_rvalid0", {31'b0, dread_valid0}, 32'h0);
      rst = 1'b1;

      // Instruction stream vectors
      for (int i = 0; i < 26; i++) begin
         en = vecs[i].en; i_mode = vecs[i].mode; instr_ready = vecs[i].ready;
         load = vecs[i].load; load_val = vecs[i].load_val;
         step();
         check($sformatf("vec%0d_valid", i), {31'b0, instr_valid3}, {31'b0, vecs[i].exp_valid});
         check($sformatf("vec%0d_instr", i), instruction3, vecs[i].exp_instr);
         check($sformatf("vec%0d_instr0", i), instruction0, vecs[i].exp_instr);
      end
      load = 1'b0;

      // Read latency: fresh reset, data counter starts at 0
      #3 rst = 1'b0;
      #1 rst = 1'b1;
      step();
      en = 1'b1; i_mode = 2'd0; d_mode = 2'd0; instr_ready = 1'b1;
      d_address = 32'h100;
      model_cnt = 32'h0;
      last_resp = 32'h0;
      for (int c = 0; c < 8; c++) begin
         mem_read = (c < 4);
         if (mem_read) begin
            exp_word = model_cnt + 32'h100;
            model_cnt = model_cnt + 32'd1;
            exp_q.push_back(exp_word);
            #1;
            check($sformatf("lat0_valid_c%0d", c), {31'b0, dread_valid0}, 32'h1);
            check($sformatf("lat0_data_c%0d", c), d_read_data0, exp_word);
         end
         step();
         exp_v = ((c + 1) >= 3) && ((c + 1) <= 6);
         check($sformatf("lat3_valid_c%0d", c + 1), {31'b0, dread_valid3}, {31'b0, exp_v});
         if (exp_v && exp_q.size() > 0) last_resp = exp_q.pop_front();
         check($sformatf("lat3_data_c%0d", c + 1), d_read_data3, last_resp);
      end
      check("lat3_queue_empty", exp_q.size(), 32'd0);

      // Load and read together: the read sees the value before the load, with no advance
      load = 1'b1; load_val = 32'h50; mem_read = 1'b1; d_address = 32'h10;
      #1;
      check("ldrd_pre", d_read_data0, 32'h14);
      step();
      load = 1'b0; d_address = 32'h0;
      #1;
      check("ldrd_post", d_read_data0, 32'h50);
      step();
      mem_read = 1'b0;
      step();
      check("ldrd_r3_valid_a", {31'b0, dread_valid3}, 32'h1);
      check("ldrd_r3_data_a", d_read_data3, 32'h14);
      step();
      check("ldrd_r3_valid_b", {31'b0, dread_valid3}, 32'h1);
      check("ldrd_r3_data_b", d_read_data3, 32'h50);
      step();
      check("ldrd_r3_idle", {31'b0, dread_valid3}, 32'h0);
      check("ldrd_r3_hold", d_read_data3, 32'h50);

      // Asynchronous reset while reads are in flight; data counter is now 0x51
      for (int c = 0; c < 3; c++) begin
         mem_read = 1'b1;
         step();
      end
      mem_read = 1'b0;
      check("arst_pre_valid", {31'b0, dread_valid3}, 32'h1);
      check("arst_pre_data", d_read_data3, 32'h51);
      #2 rst = 1'b0;
      #1;
      check("arst_rvalid", {31'b0, dread_valid3}, 32'h0);
      check("arst_rdata", d_read_data3, 32'h0);
      check("arst_ivalid", {31'b0, instr_valid3}, 32'h0);
      check("arst_instr", instruction3, 32'h0);
      en = 1'b0;
      #1 rst = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step();
         check($sformatf("arst_after_c%0d", c), {31'b0, dread_valid3}, 32'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
